// File: rtl/clock_divider_ctrl_pkg.sv
// clkctrl_pkg: shared types and elaboration helpers for clock_divider_ctrl.
//   state_t       : controller FSM state (STOPPED/RUNNING/STEPPING, 3 unused)
//   calc_prescale : clock cycles per half period of the base (stage 0) wave
//   stage_width   : width of a stage counter that counts 0..div-1
package clkctrl_pkg;

    typedef enum logic [1:0] {
        STOPPED  = 2'd0,
        RUNNING  = 2'd1,
        STEPPING = 2'd2
    } state_t;

    function automatic int calc_prescale(input int clk_hz, input int base_hz);
        return clk_hz / (2 * base_hz);
    endfunction

    function automatic int stage_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/clock_divider_ctrl_if.sv
// clock_divider_ctrl_if: switch inputs and LED-facing outputs of the divider
// controller.
//   run_i/step_i   : run level and single-step level from the board switches
//   wave_o         : per-stage 50 % square waves
//   tick_o         : one-cycle pulse on each rising edge of wave_o
//   state_o        : controller state encoding
//   master modport : board / stimulus side, slave modport : controller side
interface clock_divider_ctrl_if #(
    parameter int NUM_STAGES = 3
);
    logic                  run_i;
    logic                  step_i;
    logic [NUM_STAGES-1:0] wave_o;
    logic [NUM_STAGES-1:0] tick_o;
    logic [1:0]            state_o;

    modport master (output run_i, step_i, input  wave_o, tick_o, state_o);
    modport slave  (input  run_i, step_i, output wave_o, tick_o, state_o);
endinterface

// File: rtl/clock_divider_ctrl_stage.sv
// divider_stage: one stage of the cascaded divider.
//   clk, rst_n : clock, asynchronous active-low reset
//   ev_i       : toggle event for this stage
//   ev_o       : toggle event for the next stage (ev_i on counter wrap)
//   wave_o     : square wave, toggles on every ev_i
//   tick_o     : registered pulse in the cycle wave_o rises
module divider_stage import clkctrl_pkg::*; #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ev_i,
    output logic ev_o,
    output logic wave_o,
    output logic tick_o
);
    localparam int CW = stage_width(DIV);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(DIV - 1));
    // Combinational so the whole cascade fires in the same cycle as ev_i.
    assign ev_o = ev_i & wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            wave_o <= 1'b0;
            tick_o <= 1'b0;
        end else begin
            // Rises together with wave_o on a 0->1 toggle.
            tick_o <= ev_i & ~wave_o;
            if (ev_i) begin
                wave_o <= ~wave_o;
                cnt    <= wrap ? '0 : cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/clock_divider_ctrl.sv
// clock_divider_ctrl: run/pause/single-step controller for a cascaded clock
// divider chain. Stage k square wave runs at BASE_HZ / DIV**k.
//   clk, rst_n : board clock, asynchronous active-low reset
//   bus        : clock_divider_ctrl_if.slave (run_i, step_i, wave_o, tick_o,
//                state_o)
// Optional macro CLKCTRL_INPUT_SYNC_EN: adds 2-flop synchronizers on run_i
// and step_i (2 cycles extra input latency); without it inputs are taken as
// synchronous to clk.
module clock_divider_ctrl import clkctrl_pkg::*; #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BASE_HZ     = 10,
    parameter int NUM_STAGES  = 3,
    parameter int DIV         = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    clock_divider_ctrl_if.slave   bus
);
    localparam int PRESCALE = calc_prescale(CLK_FREQ_HZ, BASE_HZ);
    localparam int PW       = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);

    generate
        if ((CLK_FREQ_HZ % (2 * BASE_HZ)) != 0 || PRESCALE < 2 || DIV < 2) begin : g_cfg_err
            $error("clock_divider_ctrl: inexact prescale, PRESCALE < 2 or DIV < 2");
        end
    endgenerate

    logic run_s, step_s;

`ifdef CLKCTRL_INPUT_SYNC_EN
    logic [1:0] run_sync, step_sync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_sync  <= '0;
            step_sync <= '0;
        end else begin
            run_sync  <= {run_sync[0], bus.run_i};
            step_sync <= {step_sync[0], bus.step_i};
        end
    end
    assign run_s  = run_sync[1];
    assign step_s = step_sync[1];
`else
    assign run_s  = bus.run_i;
    assign step_s = bus.step_i;
`endif

    state_t        state;
    logic [PW-1:0] presc;
    logic          step_prev;
    logic          step_edge;
    logic          presc_wrap;
    logic          t0;

    assign step_edge  = step_s & ~step_prev;
    assign presc_wrap = (presc == PW'(PRESCALE - 1));
    // A step forces exactly one base event; a pause just freezes the count.
    assign t0 = ((state == RUNNING) & presc_wrap) | (state == STEPPING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= STOPPED;
            presc     <= '0;
            step_prev <= 1'b0;
        end else begin
            // History always tracks, so a step edge seen while running or
            // coincident with run is consumed, not deferred.
            step_prev <= step_s;
            case (state)
                STOPPED: begin
                    if (run_s)          state <= RUNNING;
                    else if (step_edge) state <= STEPPING;
                end
                RUNNING: begin
                    presc <= presc_wrap ? '0 : presc + 1'b1;
                    if (!run_s) state <= STOPPED;
                end
                STEPPING: begin
                    presc <= '0;
                    state <= STOPPED;
                end
                default: state <= STOPPED;
            endcase
        end
    end

    assign bus.state_o = state;

    logic [NUM_STAGES:0]   ev;
    logic [NUM_STAGES-1:0] wave, tick;
    logic                  unused_ev_top;

    assign ev[0]         = t0;
    assign unused_ev_top = ev[NUM_STAGES];

    generate
        for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
            divider_stage #(.DIV(DIV)) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .ev_i   (ev[g]),
                .ev_o   (ev[g+1]),
                .wave_o (wave[g]),
                .tick_o (tick[g])
            );
        end
    endgenerate

    assign bus.wave_o = wave;
    assign bus.tick_o = tick;
endmodule

// File: tb/tb_clock_divider_ctrl.sv
module tb_clock_divider_ctrl;
    localparam int CLK_HZ = 200;
    localparam int BASE   = 10;
    localparam int NS     = 3;
    localparam int DV     = 10;
    localparam int P      = 10;
`ifdef CLKCTRL_INPUT_SYNC_EN
    localparam int SLAT = 2;
`else
    localparam int SLAT = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clock_divider_ctrl_if #(.NUM_STAGES(NS)) bus ();

    clock_divider_ctrl #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BASE_HZ     (BASE),
        .NUM_STAGES  (NS),
        .DIV         (DV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the chain is fully described by the number of base
    // events n0 so far; stage k has toggled floor(n0 / DV**k) times.
    int m_state, m_presc, m_n0, exp_tick;
    bit m_sprev;
    bit [1:0] rq, sq;

    function automatic int wave_of(input int n);
        int w = 0, pw = 1;
        for (int k = 0; k < NS; k++) begin
            if (((n / pw) % 2) == 1) w |= (1 << k);
            pw *= DV;
        end
        return w;
    endfunction

    task automatic model_reset();
        m_state = 0; m_presc = 0; m_n0 = 0; exp_tick = 0;
        m_sprev = 0; rq = '0; sq = '0;
    endtask

    task automatic model_step();
        bit r, s, e, t0;
        int pw;
`ifdef CLKCTRL_INPUT_SYNC_EN
        r = rq[1]; s = sq[1];
        rq = {rq[0], bus.run_i};
        sq = {sq[0], bus.step_i};
`else
        r = bus.run_i; s = bus.step_i;
`endif
        e = s && !m_sprev;
        m_sprev = s;
        t0 = (m_state == 1 && m_presc == P - 1) || m_state == 2;
        if (m_state == 1) m_presc = (m_presc + 1) % P;
        else if (m_state == 2) m_presc = 0;
        exp_tick = 0;
        if (t0) begin
            m_n0++;
            pw = 1;
            for (int k = 0; k < NS; k++) begin
                if (m_n0 % pw == 0 && ((m_n0 / pw) % 2) == 1) exp_tick |= (1 << k);
                pw *= DV;
            end
        end
        case (m_state)
            0:       m_state = r ? 1 : (e ? 2 : 0);
            1:       m_state = r ? 1 : 0;
            default: m_state = 0;
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    int st2_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("wave", int'(bus.wave_o), wave_of(m_n0));
                chk("tick", int'(bus.tick_o), exp_tick);
                chk("state", int'(bus.state_o), m_state);
                if (bus.state_o == 2'd2) st2_cnt++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        cyc(2);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_tick(input int k, input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(posedge clk);
            #1;
            if (bus.tick_o[k]) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n, hi, s0;
        bus.run_i  = 1'b0;
        bus.step_i = 1'b0;
        rst_n      = 1'b0;
        cyc(3);
        chk("rst_wave", int'(bus.wave_o), 0);
        chk("rst_tick", int'(bus.tick_o), 0);
        chk("rst_state", int'(bus.state_o), 0);
        #1 rst_n = 1'b1;
        cyc(2);

        // Run and step rise together: run wins, held step gives no step.
        s0 = st2_cnt;
        bus.run_i = 1'b1; bus.step_i = 1'b1;
        n = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (bus.state_o == 2'd1) begin n = i; break; end
        end
        chk("run_latency", n, 1 + SLAT);
        cyc(3);
        bus.run_i = 1'b0;
        cyc(6);
        chk("no_step_on_hold", st2_cnt - s0, 0);
        chk("no_forced_t0", int'(bus.wave_o), 0);
        bus.step_i = 1'b0;
        cyc(3);

        // 35 running cycles, pause, resume: next T0 five cycles in.
        do_reset();
        cyc(1);
        bus.run_i = 1'b1;
        cyc(35);
        bus.run_i = 1'b0;
        cyc(10 + SLAT);
        chk("pause_state", int'(bus.state_o), 0);
        chk("pause_wave", int'(bus.wave_o), 1);
        cyc(10);
        chk("frozen_wave", int'(bus.wave_o), 1);
        bus.run_i = 1'b1;
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (bus.wave_o[0] != 1'b1) begin n = i; break; end
        end
        chk("resume_t0", n, 6 + SLAT);

        // Free-running periods and duty.
        wait_tick(0, 40, n);
        wait_tick(0, 40, n);
        chk("tick0_period", n, 20);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.wave_o[0]) hi++;
            @(posedge clk); #1;
        end
        chk("wave0_duty", hi, 10);
        wait_tick(1, 250, n);
        wait_tick(1, 250, n);
        chk("tick1_period", n, 200);
        wait_tick(2, 2100, n);
        wait_tick(2, 2100, n);
        chk("tick2_period", n, 2000);
        bus.run_i = 1'b0;
        cyc(5);

        // Single stepping from a fresh reset.
        do_reset();
        cyc(2);
        s0 = st2_cnt;
        for (int i = 0; i < 10; i++) begin
            bus.step_i = 1'b1;
            cyc(1);
            bus.step_i = 1'b0;
            cyc(4);
            if (i == 8) chk("step9_wave", int'(bus.wave_o), 1);
        end
        chk("step10_wave", int'(bus.wave_o), 2);
        chk("step_state2_cycles", st2_cnt - s0, 10);

        // Asynchronous reset mid-run.
        bus.run_i = 1'b1;
        cyc(50);
        #2 rst_n = 1'b0;
        bus.run_i = 1'b0;
        #1;
        chk("async_rst_wave", int'(bus.wave_o), 0);
        chk("async_rst_tick", int'(bus.tick_o), 0);
        chk("async_rst_state", int'(bus.state_o), 0);
        #2 rst_n = 1'b1;
        cyc(30);
        chk("idle_after_rst", int'(bus.state_o), 0);
        chk("idle_wave", int'(bus.wave_o), 0);

        // Random run/step activity against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) bus.run_i = ~bus.run_i;
            if ($urandom_range(0, 3) == 0) bus.step_i = ~bus.step_i;
            cyc(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
